regfile_write_ctrl: RTL
=======================

// Module: regfile_write_ctrl
// PURPOSE
//   Owns the single write port of the 32x32 register file. After reset, sweeps every
//   register to zero (the array itself has no reset), then shares the port between two
//   writeback requesters (A = ALU, B = load unit) with round-robin valid/ready
//   arbitration. Writes to x0 are accepted and dropped. Sits between the writeback
//   stage and the register file's reg_write/write_reg/write_data inputs.
// PARAMETERS
//   NUM_REGS        32  registers swept during clear; equals 2**ADDR_W
//   ADDR_W          5   register index width
//   DATA_W          32  write data width
//   CLEAR_ON_RESET  1   1: run clear sweep after reset; 0: enter RUN directly
// PORTS
//   clk          in   1       clock; all logic on rising edge
//   rst          in   1       synchronous, active-high reset
//   a_valid      in   1       requester A has a write pending
//   a_ready      out  1       A's write accepted this cycle (valid & ready)
//   a_rd         in   ADDR_W  A destination register
//   a_data       in   DATA_W  A write data
//   b_valid      in   1       requester B has a write pending
//   b_ready      out  1       B's write accepted this cycle
//   b_rd         in   ADDR_W  B destination register
//   b_data       in   DATA_W  B write data
//   reg_write    out  1       register-file write enable (registered)
//   write_reg    out  ADDR_W  register-file write index (registered)
//   write_data   out  DATA_W  register-file write data (registered)
//   init_done    out  1       clear sweep complete; arbitration enabled
// BEHAVIOUR
//   - Reset (rst high on a clock edge): reg_write=0, write_reg=0, write_data=0,
//     init_done=0, clear counter=0, last-grant pointer=B (A wins the first tie).
//     State -> CLEAR (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0, init_done=1 next cycle).
//     rst asserted mid-sweep or mid-RUN aborts everything; sweep restarts at index 0.
//   - States: CLEAR, RUN. No other states; illegal encodings go to CLEAR.
//   - CLEAR: each cycle drive registered reg_write=1, write_reg=cnt, write_data=0;
//     cnt increments 0..NUM_REGS-1 (exactly NUM_REGS cycles, x0 included).
//     After index NUM_REGS-1 is issued -> RUN; init_done=1 from the next cycle on.
//     a_ready=b_ready=0 throughout CLEAR; requesters hold their payload.
//   - RUN: a_ready/b_ready are combinational from valids and pointer, at most one high:
//       only A valid -> a_ready=1; only B valid -> b_ready=1;
//       both valid -> grant the requester NOT granted last; pointer updates on every grant.
//   - Latency: accepted write appears on reg_write/write_reg/write_data exactly 1 cycle
//     after the accept cycle. Port throughput: one write per cycle, no bubbles.
//   - rd==0: request is accepted (ready=1, pointer updates), but next cycle reg_write=0.
//   - No accept in a RUN cycle: next cycle reg_write=0; write_reg/write_data hold their
//     previous values.
//   - Same rd from A and B in consecutive grants: both writes issued in grant order;
//     the later one wins in the array. No merging or reordering.
//   - valid must stay high with stable payload until ready; controller never drops a
//     pending request and never grants a non-valid requester.
// TESTING
//   1. rst 1 cycle, then idle -> reg_write=1 for 32 cycles, write_reg 0..31, data 0;
//      init_done rises the cycle after write_reg=31; readies 0 during sweep.
//   2. After init, a_valid only, a_rd=5, a_data=0xDEADBEEF -> a_ready=1 same cycle;
//      next cycle reg_write=1, write_reg=5, write_data=0xDEADBEEF.
//   3. Both valid for 4 cycles (A rd=1..4, B rd=9..12, advancing on accept) ->
//      grants A,B,A,B; write_reg sequence 1,9,2,10.
//   4. b_valid, b_rd=0, b_data=0x1234 -> b_ready=1; next cycle reg_write=0;
//      following A/B tie grants A (pointer moved to B).
//   5. rst pulsed at sweep index 17 -> sweep restarts at write_reg=0, 32 full writes,
//      init_done stays 0 until restarted sweep completes.
//   6. CLEAR_ON_RESET=0: rst then a_valid rd=3 -> no sweep; init_done=1 cycle after
//      reset; write to x3 issued 1 cycle after accept.

Source files
------------

// File: rtl/regfile_write_ctrl_if.sv
// Writeback-to-register-file bus: two valid/ready requesters in, one registered
// write port plus init status out.
interface regfile_write_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              reg_write;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              init_done;

  // Requester / register-file side.
  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, reg_write, write_reg, write_data, init_done
  );

  // Controller side.
  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, reg_write, write_reg, write_data, init_done
  );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port owner: zero-sweeps the array after reset, then
// round-robin arbitrates the ALU (A) and load unit (B) onto the single write port.
module regfile_write_ctrl #(
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic                clk,
  input logic                rst,
  regfile_write_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_b_q, last_b_d;  // 1: B was granted most recently
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              init_done_q, init_done_d;
  logic              grant_a, grant_b;

  // Round-robin grant; only live once the sweep has completed.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == StRun && init_done_q) begin
      grant_a = bus.a_valid && (!bus.b_valid || last_b_q);
      grant_b = bus.b_valid && (!bus.a_valid || !last_b_q);
    end
  end

  assign bus.a_ready    = grant_a;
  assign bus.b_ready    = grant_b;
  assign bus.reg_write  = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.init_done  = init_done_q;

  // Next-state: clear sweep, then registered issue of the granted write.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_b_d     = last_b_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    init_done_d  = init_done_q;
    unique case (state_q)
      StClear: begin
        init_done_d  = 1'b0;
        reg_write_d  = 1'b1;
        write_reg_d  = cnt_q;
        write_data_d = '0;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        init_done_d = 1'b1;
        if (grant_a) begin
          last_b_d = 1'b0;
          // x0 writes are consumed but never reach the array.
          if (bus.a_rd != '0) begin
            reg_write_d  = 1'b1;
            write_reg_d  = bus.a_rd;
            write_data_d = bus.a_data;
          end
        end else if (grant_b) begin
          last_b_d = 1'b1;
          if (bus.b_rd != '0) begin
            reg_write_d  = 1'b1;
            write_reg_d  = bus.b_rd;
            write_data_d = bus.b_data;
          end
        end
      end
      default: begin
        state_d     = StClear;
        cnt_d       = '0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR_ON_RESET ? StClear : StRun;
      cnt_q        <= '0;
      last_b_q     <= 1'b1;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_b_q     <= last_b_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      init_done_q  <= init_done_d;
    end
  end

endmodule
